// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback driver for the RV64I core.
// Formats load data, selects the writeback source, blocks x0 writes and counts retired instructions.
module mem_wb_writeback #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic [XLEN-1:0]   mem_read_data,
  input  logic [XLEN-1:0]   mem_pc_plus4,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [1:0]        mem_wb_sel,
  input  logic [2:0]        mem_funct3,
  input  logic              wb_stall,
  input  logic              wb_flush,
  output logic [XLEN-1:0]   rf_write_data,
  output logic [REG_AW-1:0] rf_rd,
  output logic              rf_reg_write,
  output logic              wb_valid,
  output logic              wb_load_fault,
  output logic [63:0]       instret
);

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  // Shift the addressed byte down to bit 0, then truncate and extend per funct3.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] data,
                                               input logic [2:0]      off,
                                               input logic [2:0]      f3);
    logic [XLEN-1:0] sh;
    sh = data >> {off, 3'b000};
    case (f3)
      3'b000:  return {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  return {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b010:  return {{(XLEN-32){sh[31]}}, sh[31:0]};
      3'b011:  return sh;
      3'b100:  return {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, sh[15:0]};
      3'b110:  return {{(XLEN-32){1'b0}}, sh[31:0]};
      default: return {XLEN{1'b0}};
    endcase
  endfunction

  function automatic logic load_bad(input logic [2:0] off, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return (off[1:0] != 2'b00);
      2'b11:   return f3[2] || (off != 3'b000);
      default: return 1'b1;
    endcase
  endfunction

  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              we_q, we_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [63:0]       instret_q, instret_d;

  logic              is_load;
  logic              load_fault;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   wb_data;

  // Writeback source selection and load fault detection.
  always_comb begin
    is_load    = (mem_wb_sel == SEL_LOAD);
    load_data  = fmt_load(mem_read_data, mem_alu_result[2:0], mem_funct3);
    load_fault = is_load && load_bad(mem_alu_result[2:0], mem_funct3);
    case (mem_wb_sel)
      SEL_LOAD: wb_data = load_data;
      SEL_LINK: wb_data = mem_pc_plus4;
      default:  wb_data = mem_alu_result;
    endcase
  end

  // Next-state: flush beats stall beats capture; a non-valid capture is a bubble.
  always_comb begin
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    we_d      = we_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    instret_d = instret_q;
    if (wb_flush || (!wb_stall && !mem_valid)) begin
      wdata_d = {XLEN{1'b0}};
      rd_d    = {REG_AW{1'b0}};
      we_d    = 1'b0;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (wb_stall) begin
      instret_d = instret_q;
    end else begin
      valid_d   = 1'b1;
      fault_d   = load_fault;
      rd_d      = mem_rd;
      // The register file does not protect x0, so rd==0 must never assert the write.
      we_d      = mem_reg_write && (mem_rd != {REG_AW{1'b0}}) && !load_fault;
      wdata_d   = load_fault ? {XLEN{1'b0}} : wb_data;
      instret_d = instret_q + 64'd1;
    end
  end

  // WB state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdata_q   <= {XLEN{1'b0}};
      rd_q      <= {REG_AW{1'b0}};
      we_q      <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      instret_q <= 64'd0;
    end else begin
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      instret_q <= instret_d;
    end
  end

  assign rf_write_data = wdata_q;
  assign rf_rd         = rd_q;
  assign rf_reg_write  = we_q;
  assign wb_valid      = valid_q;
  assign wb_load_fault = fault_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Scoreboard bench for mem_wb_writeback: expectations from a bench-side model, compared one cycle later.
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [63:0] mem_alu_result, mem_read_data, mem_pc_plus4;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic        wb_stall, wb_flush;
  logic [63:0] rf_write_data;
  logic [4:0]  rf_rd;
  logic        rf_reg_write, wb_valid, wb_load_fault;
  logic [63:0] instret;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] wd;
    logic [4:0]  rd;
    logic        we;
    logic        v;
    logic        f;
    logic [63:0] ir;
    logic        known;
  } exp_t;

  exp_t        m;
  exp_t        sb[$];
  logic [63:0] rf[32];

  mem_wb_writeback dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data), .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .wb_stall(wb_stall), .wb_flush(wb_flush), .rf_write_data(rf_write_data), .rf_rd(rf_rd),
    .rf_reg_write(rf_reg_write), .wb_valid(wb_valid), .wb_load_fault(wb_load_fault),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // Register file fed by the write port, as the core's would be.
  always @(posedge clk) begin
    if (rf_reg_write) rf[rf_rd] <= rf_write_data;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-gathering load model, independent of shift-based formatting.
  function automatic logic [63:0] model_load(input logic [63:0] d, input logic [2:0] a,
                                             input logic [2:0] f3, output logic flt);
    int sz;
    logic [63:0] r;
    sz  = 1 << f3[1:0];
    flt = (f3 == 3'b111) || ((int'(a) % sz) != 0);
    r   = 64'd0;
    if (!flt) begin
      for (int k = 0; k < sz; k++) r[8*k +: 8] = d[8*(int'(a)+k) +: 8];
      if (!f3[2] && sz < 8)
        for (int b = 8*sz; b < 64; b++) r[b] = r[8*sz-1];
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [63:0] alu, input logic [63:0] rdata,
                       input logic [63:0] pc4, input logic [4:0] rd, input logic rw,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic stall, input logic flush);
    exp_t e;
    logic flt;
    logic [63:0] ld;
    mem_valid = v; mem_alu_result = alu; mem_read_data = rdata; mem_pc_plus4 = pc4;
    mem_rd = rd; mem_reg_write = rw; mem_wb_sel = sel; mem_funct3 = f3;
    wb_stall = stall; wb_flush = flush;
    if (flush) begin
      m.wd = 64'd0; m.rd = 5'd0; m.we = 1'b0; m.v = 1'b0; m.f = 1'b0; m.known = 1'b1;
    end else if (stall) begin
      m = m;
    end else if (!v) begin
      m.we = 1'b0; m.v = 1'b0; m.f = 1'b0; m.known = 1'b0;
    end else begin
      ld  = model_load(rdata, alu[2:0], f3, flt);
      flt = flt && (sel == 2'b01);
      m.v = 1'b1;
      m.f = flt;
      m.rd = rd;
      m.we = rw && (rd != 5'd0) && !flt;
      m.wd = flt ? 64'd0 : (sel == 2'b01) ? ld : (sel == 2'b10) ? pc4 : alu;
      m.ir = m.ir + 64'd1;
      m.known = 1'b1;
    end
    sb.push_back(m);
    @(negedge clk);
    e = sb.pop_front();
    if (e.known) begin
      check_eq("wdata", rf_write_data, e.wd);
      check_eq("rd", {59'd0, rf_rd}, {59'd0, e.rd});
    end
    check_eq("we", {63'd0, rf_reg_write}, {63'd0, e.we});
    check_eq("valid", {63'd0, wb_valid}, {63'd0, e.v});
    check_eq("fault", {63'd0, wb_load_fault}, {63'd0, e.f});
    check_eq("instret", instret, e.ir);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_wdata"}, rf_write_data, 64'd0);
    check_eq({tag, "_rd"}, {59'd0, rf_rd}, 64'd0);
    check_eq({tag, "_we"}, {63'd0, rf_reg_write}, 64'd0);
    check_eq({tag, "_valid"}, {63'd0, wb_valid}, 64'd0);
    check_eq({tag, "_fault"}, {63'd0, wb_load_fault}, 64'd0);
    check_eq({tag, "_instret"}, instret, 64'd0);
  endtask

  localparam logic [63:0] D = 64'h8877_6655_4433_2211;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    m = '0;
    reset = 1'b1; mem_valid = 1'b0; mem_alu_result = 64'd0; mem_read_data = 64'd0;
    mem_pc_plus4 = 64'd0; mem_rd = 5'd0; mem_reg_write = 1'b0; mem_wb_sel = 2'b00;
    mem_funct3 = 3'b000; wb_stall = 1'b0; wb_flush = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    drive(1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);

    // ALU writeback, then one more edge for the register file to commit.
    drive(1'b1, 64'h1234, 64'd0, 64'd0, 5'd5, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    check_eq("rf_x5", rf[5], 64'h1234);

    // Load formatting.
    drive(1'b1, 64'h1007, D, 64'd0, 5'd6, 1'b1, 2'b01, 3'b000, 1'b0, 1'b0);
    check_eq("lb_const", rf_write_data, 64'hFFFF_FFFF_FFFF_FF88);
    drive(1'b1, 64'h1007, D, 64'd0, 5'd6, 1'b1, 2'b01, 3'b100, 1'b0, 1'b0);
    check_eq("lbu_const", rf_write_data, 64'h88);
    drive(1'b1, 64'h1004, D, 64'd0, 5'd7, 1'b1, 2'b01, 3'b010, 1'b0, 1'b0);
    check_eq("lw_const", rf_write_data, 64'hFFFF_FFFF_8877_6655);
    drive(1'b1, 64'h1004, D, 64'd0, 5'd7, 1'b1, 2'b01, 3'b110, 1'b0, 1'b0);
    check_eq("lwu_const", rf_write_data, 64'h8877_6655);
    drive(1'b1, 64'h1000, D, 64'd0, 5'd8, 1'b1, 2'b01, 3'b011, 1'b0, 1'b0);
    drive(1'b1, 64'h1006, D, 64'd0, 5'd9, 1'b1, 2'b01, 3'b001, 1'b0, 1'b0);
    drive(1'b1, 64'h1002, D, 64'd0, 5'd9, 1'b1, 2'b01, 3'b101, 1'b0, 1'b0);
    drive(1'b1, 64'h1001, D, 64'd0, 5'd9, 1'b1, 2'b01, 3'b100, 1'b0, 1'b0);

    // Faults: misaligned lw, illegal funct3, misaligned ld; misalignment ignored for non-loads.
    drive(1'b1, 64'h1002, D, 64'd0, 5'd10, 1'b1, 2'b01, 3'b010, 1'b0, 1'b0);
    check_eq("lw_mis_fault", {63'd0, wb_load_fault}, 64'd1);
    drive(1'b1, 64'h1000, D, 64'd0, 5'd10, 1'b1, 2'b01, 3'b111, 1'b0, 1'b0);
    drive(1'b1, 64'h1004, D, 64'd0, 5'd10, 1'b1, 2'b01, 3'b011, 1'b0, 1'b0);
    drive(1'b1, 64'h1003, D, 64'd0, 5'd11, 1'b1, 2'b00, 3'b111, 1'b0, 1'b0);

    // x0 protection, link value, reserved select, reg_write=0.
    drive(1'b1, 64'hDEAD, 64'd0, 64'd0, 5'd0, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 64'h55, 64'd0, 64'h1004, 5'd1, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0);
    check_eq("link_const", rf_write_data, 64'h1004);
    drive(1'b1, 64'h77, 64'd0, 64'h1008, 5'd2, 1'b1, 2'b11, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 64'h99, 64'd0, 64'd0, 5'd3, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);

    // Stall three cycles with changing inputs, then release.
    drive(1'b1, 64'hABCD, 64'd0, 64'd0, 5'd12, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b1, $urandom, $urandom, $urandom, 5'(i + 20), 1'b1, 2'(i), 3'(i), 1'b1, 1'b0);
    check_eq("stall_hold", rf_write_data, 64'hABCD);
    drive(1'b1, 64'h4242, 64'd0, 64'd0, 5'd13, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0);

    // Stall + flush, and plain flush.
    drive(1'b1, 64'h1111, 64'd0, 64'd0, 5'd14, 1'b1, 2'b00, 3'b000, 1'b1, 1'b1);
    drive(1'b1, 64'h2222, 64'd0, 64'd0, 5'd15, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 64'h3333, 64'd0, 64'd0, 5'd16, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1);

    // Counter wrap.
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    m.ir = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1'b1, 64'h5, 64'd0, 64'd0, 5'd17, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0);
    check_eq("wrap_const", instret, 64'd0);
    drive(1'b1, 64'h6, 64'd0, 64'd0, 5'd17, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0);

    // Reset wins over a simultaneous stall and flush.
    reset = 1'b1; wb_stall = 1'b1; wb_flush = 1'b1; mem_valid = 1'b1;
    @(negedge clk);
    check_zero("rst_stall");
    reset = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
